// File: rtl/pio_led_sequencer.sv
// Turns the 2-bit PIO mode value into an LED pattern: off, steady on, timed blink or one-hot chase.
// Blink and chase steps are timed by one shared prescaler that restarts on every mode change.
module pio_led_sequencer #(
  parameter int LED_W    = 8,
  parameter int SLOW_DIV = 25000000,
  parameter int FAST_DIV = 2500000
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [1:0]       cmd,
  output logic [LED_W-1:0] led,
  output logic [1:0]       mode,
  output logic             active,
  output logic             tick
);

  localparam int MAX_DIV = (SLOW_DIV > FAST_DIV) ? SLOW_DIV : FAST_DIV;
  localparam int CNT_W   = (MAX_DIV > 1) ? $clog2(MAX_DIV) : 1;
  localparam logic [CNT_W-1:0] SLOW_LAST = CNT_W'(SLOW_DIV - 1);
  localparam logic [CNT_W-1:0] FAST_LAST = CNT_W'(FAST_DIV - 1);

  typedef enum logic [1:0] {
    S_OFF   = 2'b00,
    S_ON    = 2'b01,
    S_BLINK = 2'b10,
    S_CHASE = 2'b11
  } state_t;

  state_t             mode_q, mode_d;
  logic [LED_W-1:0]   led_q, led_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               tick_q, tick_d;
  logic               change;

  always_ff @(posedge clk) begin
    if (reset) begin
      mode_q <= S_OFF;
      led_q  <= '0;
      cnt_q  <= '0;
      tick_q <= 1'b0;
    end else begin
      mode_q <= mode_d;
      led_q  <= led_d;
      cnt_q  <= cnt_d;
      tick_q <= tick_d;
    end
  end

  assign change = (cmd != 2'(mode_q));

  always_comb begin
    mode_d = state_t'(cmd);
    led_d  = led_q;
    cnt_d  = '0;
    tick_d = 1'b0;
    if (change) begin
      // a mode change always wins over a coincident terminal count
      unique case (state_t'(cmd))
        S_OFF:   led_d = '0;
        S_ON:    led_d = '1;
        S_BLINK: led_d = '1;
        S_CHASE: led_d = LED_W'(1);
        default: led_d = '0;
      endcase
    end else begin
      unique case (mode_q)
        S_BLINK: begin
          if (cnt_q == SLOW_LAST) begin
            tick_d = 1'b1;
            led_d  = ~led_q;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        S_CHASE: begin
          if (cnt_q == FAST_LAST) begin
            tick_d = 1'b1;
            led_d  = {led_q[LED_W-2:0], led_q[LED_W-1]};
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    led    = led_q;
    mode   = mode_q;
    active = (mode_q != S_OFF);
    tick   = tick_q;
  end

endmodule

// File: tb/tb_pio_led_sequencer.sv
// Bench for pio_led_sequencer: directed plan steps with literal expectations, then random mode/reset
// traffic; every cycle is compared against a model that derives outputs from time spent in the mode.
module tb_pio_led_sequencer;

  localparam int LW = 4;
  localparam int SD = 4;
  localparam int FD = 3;

  logic          clk = 1'b0;
  logic          reset;
  logic [1:0]    cmd;
  logic [LW-1:0] led;
  logic [1:0]    mode;
  logic          active;
  logic          tick;

  int n_checks = 0;
  int n_fail   = 0;
  bit done     = 0;

  int m_mode = 0;
  int m_k    = 0;

  pio_led_sequencer #(.LED_W(LW), .SLOW_DIV(SD), .FAST_DIV(FD)) dut (
    .clk(clk), .reset(reset), .cmd(cmd),
    .led(led), .mode(mode), .active(active), .tick(tick)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  // Pattern as a function of mode and cycles elapsed since the entry edge.
  function automatic logic [LW-1:0] exp_led(input int m, input int k);
    logic [LW-1:0] one;
    one = 1;
    case (m)
      1:       return '1;
      2:       return (((k / SD) % 2) == 0) ? '1 : '0;
      3:       return one << ((k / FD) % LW);
      default: return '0;
    endcase
  endfunction

  function automatic logic exp_tick(input int m, input int k);
    if (m == 2) return (k > 0) && ((k % SD) == 0);
    if (m == 3) return (k > 0) && ((k % FD) == 0);
    return 1'b0;
  endfunction

  always @(posedge clk) begin
    if (reset) begin
      m_mode = 0;
      m_k    = 0;
    end else if (int'(cmd) != m_mode) begin
      m_mode = int'(cmd);
      m_k    = 0;
    end else begin
      m_k++;
    end
    #1;
    if (!done) begin
      check("model_led",    32'(led),    32'(exp_led(m_mode, m_k)));
      check("model_mode",   32'(mode),   32'(m_mode));
      check("model_active", 32'(active), 32'(m_mode != 0));
      check("model_tick",   32'(tick),   32'(exp_tick(m_mode, m_k)));
    end
  end

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  int ticks_seen;

  initial begin
    reset = 1'b1;
    cmd   = 2'b11;
    // reset held with CHASE requested
    step(3);
    check("rst_led",  32'(led),  32'h0);
    check("rst_mode", 32'(mode), 32'h0);
    check("rst_tick", 32'(tick), 32'h0);
    reset = 1'b0;
    step(1);
    check("rel_led",  32'(led),  32'h1);
    check("rel_mode", 32'(mode), 32'h3);

    // BLINK from OFF
    cmd = 2'b00;
    step(1);
    check("off_led", 32'(led), 32'h0);
    cmd = 2'b10;
    step(1);
    check("blink_entry", 32'(led), 32'hF);
    step(3);
    check("blink_hold", 32'(led), 32'hF);
    step(1);
    check("blink_off",  32'(led),  32'h0);
    check("blink_tick", 32'(tick), 32'h1);
    step(4);
    check("blink_on2",   32'(led),  32'hF);
    check("blink_tick2", 32'(tick), 32'h1);

    // CHASE rotation and wrap
    cmd = 2'b11;
    step(1);
    check("chase_entry", 32'(led), 32'h1);
    for (int i = 1; i <= 4; i++) begin
      step(2);
      check("chase_notick", 32'(tick), 32'h0);
      step(1);
      check("chase_led",  32'(led),  32'(1 << (i % 4)));
      check("chase_tick", 32'(tick), 32'h1);
    end

    // change on the terminal-count cycle
    cmd = 2'b10;
    step(1);
    check("t4_entry", 32'(led), 32'hF);
    step(3);
    cmd = 2'b01;
    step(1);
    check("t4_led",  32'(led),  32'hF);
    check("t4_mode", 32'(mode), 32'h1);
    check("t4_tick", 32'(tick), 32'h0);
    step(10);
    check("t4_hold", 32'(led), 32'hF);

    // reset mid-chase
    cmd = 2'b11;
    step(1);
    step(6);
    check("t5_pre", 32'(led), 32'h4);
    reset = 1'b1;
    step(1);
    check("t5_rst_led",  32'(led),  32'h0);
    check("t5_rst_mode", 32'(mode), 32'h0);
    reset = 1'b0;
    step(1);
    check("t5_restart", 32'(led), 32'h1);
    step(2);
    check("t5_hold", 32'(led), 32'h1);
    step(1);
    check("t5_step", 32'(led),  32'h2);
    check("t5_tick", 32'(tick), 32'h1);

    // OFF and ON are static
    cmd = 2'b00;
    step(1);
    check("t6_off_led",    32'(led),    32'h0);
    check("t6_off_active", 32'(active), 32'h0);
    cmd = 2'b01;
    step(1);
    check("t6_on_led",    32'(led),    32'hF);
    check("t6_on_active", 32'(active), 32'h1);
    ticks_seen = 0;
    for (int i = 0; i < 50; i++) begin
      step(1);
      if (tick === 1'b1) ticks_seen++;
    end
    check("t6_no_tick", 32'(ticks_seen), 32'h0);

    // random mode changes and occasional resets
    for (int i = 0; i < 400; i++) begin
      cmd   = 2'($urandom_range(0, 3));
      reset = ($urandom_range(0, 15) == 0);
      step(1);
      reset = 1'b0;
      step($urandom_range(0, 14));
    end

    step(2);
    done = 1;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/pio_led_sequencer.md
# pio_led_sequencer

Downstream consumer of the 2-bit Avalon PIO output port. It interprets the PIO value as a display mode and drives an LED bank: off, steady on, timed blink, or a rotating one-hot chase. All timing is derived from prescaler counters, so software only writes one 2-bit value per mode change.

## Interface
- `LED_W`, 8: number of LED outputs; must be ≥ 2.
- `SLOW_DIV`, 25000000: clock cycles per blink phase in BLINK mode; must be ≥ 1.
- `FAST_DIV`, 2500000: clock cycles per chase step in CHASE mode; must be ≥ 1.
- `clk` input 1: single system clock, the same clock as the PIO.
- `reset` input 1: synchronous, active-high reset.
- `cmd` input 2: mode select, driven directly from the PIO `out_port`. 00 OFF, 01 ON, 10 BLINK, 11 CHASE.
- `led` output LED_W: LED drive, registered.
- `mode` output 2: currently active mode (registered copy of `cmd`).
- `active` output 1: high when `mode` is not 00. Combinational from `mode`.
- `tick` output 1: one-cycle pulse on every timed pattern update. Registered.

## Operation
- **Mode register.** `cmd` is synchronous to `clk`, so no synchronizer is needed.
  - Register `mode_q` holds the active mode.
  - A change is detected when `cmd != mode_q`.
- **On a change (next edge):**
  - `mode_q <= cmd`.
  - Prescaler `cnt <= 0`.
  - `tick <= 0`.
  - `led` is loaded with the entry pattern: OFF = all 0; ON = all 1; BLINK = all 1 (on phase first); CHASE = one-hot at bit 0.
- **No change, OFF or ON:** `led` holds, `cnt` stays 0, `tick` stays 0.
- **No change, BLINK or CHASE:**
  - `cnt` increments each cycle.
  - Terminal value is `SLOW_DIV-1` (BLINK) or `FAST_DIV-1` (CHASE).
  - At terminal: `cnt <= 0` and `tick <= 1` for that one cycle.
  - BLINK at terminal: `led <= ~led`.
  - CHASE at terminal: rotate left by one. The MSB wraps to bit 0.
  - Otherwise `tick <= 0`.
- **Counter width:** `$clog2(max(SLOW_DIV, FAST_DIV))`, minimum 1 bit. The counter never exceeds the terminal value. A DIV of 1 updates every cycle.
- **States:** OFF, ON, BLINK, CHASE, encoded as `mode_q`. Any state can move to any other on a `cmd` change; no other transitions exist.
- **Rewriting the same value:** if software writes the value already on the PIO, `cmd` does not change, so the pattern does not restart. This is intended behaviour.
- **Returning to a mode:** leaving a mode and re-entering it always restarts from that mode's entry pattern.

## Timing
- **Reset** (wins over every other condition):
  - `led` = 0, `mode` = 00, `active` = 0, `tick` = 0, `cnt` = 0.
  - If `cmd` is nonzero when `reset` deasserts, the first edge after deassertion is treated as a change. The entry pattern is visible one cycle after release.
- **Mode latency:** `cmd` changes before edge N; `led`, `mode` and `active` show the new mode after edge N (1 cycle).
- **First timed update:** occurs DIV edges after the entry edge. Each update follows DIV cycles after the previous one. `tick` is high in exactly the cycle the new `led` value first appears.
- **Change coinciding with terminal count:** the change wins. The entry pattern is loaded, `cnt` = 0, and no `tick` is emitted.
- **Reset mid-sequence:** the pattern is abandoned immediately, with no partial step.
- **Duty cycle:** BLINK produces an exact 50% duty square wave with period `2*SLOW_DIV`. CHASE has period `LED_W*FAST_DIV`.

## Test plan
Bench parameters: `LED_W`=4, `SLOW_DIV`=4, `FAST_DIV`=3.

1. **Reset behaviour.** Hold `reset` with `cmd`=11, then release. Required: during reset `led`=0000, `mode`=00, `tick`=0. One cycle after release `led`=0001 and `mode`=11.
2. **BLINK timing.** Set `cmd`=10 from OFF. Required: `led`=1111 after 1 cycle; 0000 four cycles later with `tick` high in that cycle; 1111 four cycles after that. `tick` never pulses twice within 4 cycles.
3. **CHASE rotation and wrap.** Set `cmd`=11. Required: `led` sequence 0001, 0010, 0100, 1000, 0001, stepping every 3 cycles with one `tick` per step.
4. **Change at terminal count.** In BLINK, switch `cmd` to 01 on the cycle where `cnt`=3. Required: next `led`=1111, `mode`=01, `tick`=0, and `led` holds thereafter.
5. **Reset mid-chase.** Run CHASE with `led`=0100, then pulse `reset` for 1 cycle while `cmd` stays 11. Required: `led`=0000 during reset, then 0001 and a full 3-cycle restart.
6. **OFF and ON are static.** `cmd`=00 then 01. Required: `led`=0000 then 1111, `active` goes 0 then 1, and no `tick` over 50 cycles.
